// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: default geometry, thresholds
// and the depth helper used to size memory and full detection.
package fifo_pkg;

    localparam int DEF_DSIZE    = 8;
    localparam int DEF_ASIZE    = 4;
    localparam int DEF_AE_LEVEL = 2;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    localparam int DEF_AF_LEVEL = fifo_depth(DEF_ASIZE) - 2;

    // Pointer/occupancy type for the default geometry (one extra wrap bit).
    typedef logic [DEF_ASIZE:0] def_ptr_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo; the FIFO uses the slave modport and
// the surrounding logic drives the master side.
interface sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int ASIZE = DEF_ASIZE
);
    // Handshake: a write transfers on a rising edge where winc=1 and wfull=0;
    // a read transfers where rinc=1 and rempty=0. Requests made against a
    // full/empty FIFO are dropped and latch the sticky overflow/underflow flag.
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             walmost_full;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output winc, wdata, rinc, clr_err,
        input  wfull, walmost_full, rdata, rempty, ralmost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, clr_err,
        output wfull, walmost_full, rdata, rempty, ralmost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// Dual-port FIFO storage: synchronous write, read port either combinational
// (first-word-fall-through) or registered with an async-reset output.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int ASIZE = DEF_ASIZE,
    parameter int FWFT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic             re_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);

    // Storage is deliberately not reset.
    logic [DSIZE-1:0] mem_q [fifo_depth(ASIZE)];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic unused_ok;
            assign unused_ok = &{1'b0, rst_n, re_i};
            assign rdata_o   = mem_q[raddr_i];
        end else begin : g_reg
            logic [DSIZE-1:0] rdata_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    rdata_q <= '0;
                else if (re_i) rdata_q <= mem_q[raddr_i];
            end
            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with optional FWFT read, almost-full/empty thresholds,
// occupancy count and sticky overflow/underflow flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE    = DEF_DSIZE,
    parameter int ASIZE    = DEF_ASIZE,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = fifo_depth(ASIZE) - 2,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic         clk,
    input  logic         rst_n,
    sync_fifo_if.slave   bus
);

    typedef logic [ASIZE:0] ptr_t;

    localparam ptr_t DEPTH_P = ptr_t'(fifo_depth(ASIZE));
    localparam ptr_t AF_P    = ptr_t'(AF_LEVEL);
    localparam ptr_t AE_P    = ptr_t'(AE_LEVEL);

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t count_q, count_d;
    logic wfull_q, rempty_q, walmost_full_q, ralmost_empty_q;
    logic overflow_q, overflow_d, underflow_q, underflow_d;
    logic we, re;
    logic [DSIZE-1:0] mem_rdata;

    // Accept decisions use only registered flags, so a full FIFO refuses a
    // write even when a read frees a slot on the same edge (and vice versa).
    assign we = bus.winc & ~wfull_q;
    assign re = bus.rinc & ~rempty_q;

    always_comb begin
        wptr_d      = wptr_q + ptr_t'(we);
        rptr_d      = rptr_q + ptr_t'(re);
        count_d     = wptr_d - rptr_d;
        overflow_d  = (bus.winc & wfull_q)  | (overflow_q  & ~bus.clr_err);
        underflow_d = (bus.rinc & rempty_q) | (underflow_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            wfull_q         <= 1'b0;
            rempty_q        <= 1'b1;
            walmost_full_q  <= 1'b0;
            ralmost_empty_q <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            wfull_q         <= (count_d == DEPTH_P);
            rempty_q        <= (count_d == '0);
            walmost_full_q  <= (count_d >= AF_P);
            ralmost_empty_q <= (count_d <= AE_P);
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .FWFT  (FWFT)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .waddr_i (wptr_q[ASIZE-1:0]),
        .wdata_i (bus.wdata),
        .re_i    (re),
        .raddr_i (rptr_q[ASIZE-1:0]),
        .rdata_o (mem_rdata)
    );

    // In FWFT mode the word is masked to zero while empty so reset reads as 0.
    assign bus.rdata         = (FWFT != 0 && rempty_q) ? '0 : mem_rdata;
    assign bus.wfull         = wfull_q;
    assign bus.rempty        = rempty_q;
    assign bus.walmost_full  = walmost_full_q;
    assign bus.ralmost_empty = ralmost_empty_q;
    assign bus.count         = count_q;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;

endmodule
